// File: rtl/jacobi_pkg.sv
// Shared types and helpers for the Jacobi relaxation engine.
// Optional convergence stop is enabled by defining JACOBI_CONV_EN.
package jacobi_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_NU     = 10;
   localparam int DEF_ITER_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bit offset of cell idx inside a packed cell vector.
   function automatic int cell_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/jacobi_cell.sv
// One Jacobi cell: floor average of its two neighbours, plus the absolute
// change against the current value when JACOBI_CONV_EN is defined.
module jacobi_cell
   import jacobi_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic [WIDTH-1:0] cur,
`ifdef JACOBI_CONV_EN
   output logic [WIDTH-1:0] delta,
`endif
   output logic [WIDTH-1:0] next
);

   // One extra bit holds the carry so the average never wraps.
   logic [WIDTH:0] sum;

   assign sum  = {1'b0, left} + {1'b0, right};
   assign next = sum[WIDTH:1];

`ifdef JACOBI_CONV_EN
   assign delta = (cur > next) ? (cur - next) : (next - cur);
`else
   logic unused_cur;
   assign unused_cur = ^cur;
`endif

endmodule

// File: rtl/jacobi_engine.sv
// Sequential 1-D Jacobi relaxation engine: one parallel sweep per clock with a
// start/done handshake. Define JACOBI_CONV_EN to enable early stop on tolerance.
module jacobi_engine
   import jacobi_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NU     = DEF_NU,
   parameter int ITER_W = DEF_ITER_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH*NU-1:0]   u_init,
   input  logic [WIDTH-1:0]      bnd_left,
   input  logic [WIDTH-1:0]      bnd_right,
   input  logic [ITER_W-1:0]     max_iters,
   input  logic [WIDTH-1:0]      tol,
   output logic                  busy,
   output logic                  done,
   output logic                  converged,
   output logic [ITER_W-1:0]     iter_count,
   output logic [WIDTH*NU-1:0]   u_out
);

   state_t            state;
   logic [WIDTH-1:0]  cells [NU];
   logic [WIDTH-1:0]  nxt   [NU];
   logic [WIDTH-1:0]  bl_r;
   logic [WIDTH-1:0]  br_r;
   logic [ITER_W-1:0] limit_r;
   logic              last_sweep;
   logic              conv_hit;

`ifdef JACOBI_CONV_EN
   logic [WIDTH-1:0]  tol_r;
   logic [WIDTH-1:0]  dlt [NU];
   logic [WIDTH-1:0]  max_delta;
`else
   logic unused_tol;
   assign unused_tol = ^tol;
`endif

   for (genvar gi = 0; gi < NU; gi++) begin : g_cell
      logic [WIDTH-1:0] lnb;
      logic [WIDTH-1:0] rnb;

      if (gi == 0) begin : g_lb
         assign lnb = bl_r;
      end else begin : g_ln
         assign lnb = cells[gi-1];
      end

      if (gi == NU-1) begin : g_rb
         assign rnb = br_r;
      end else begin : g_rn
         assign rnb = cells[gi+1];
      end

      jacobi_cell #(.WIDTH(WIDTH)) u_cell (
         .left  (lnb),
         .right (rnb),
         .cur   (cells[gi]),
`ifdef JACOBI_CONV_EN
         .delta (dlt[gi]),
`endif
         .next  (nxt[gi])
      );

      assign u_out[cell_lsb(gi, WIDTH) +: WIDTH] = cells[gi];
   end

`ifdef JACOBI_CONV_EN
   always_comb begin
      // NOTE: default first so every path assigns max_delta and no latch is inferred.
      max_delta = '0;
      for (int i = 0; i < NU; i++) begin
         if (dlt[i] > max_delta) max_delta = dlt[i];
      end
   end

   assign conv_hit = (max_delta <= tol_r);
`else
   assign conv_hit = 1'b0;
`endif

   // The counter stays below the limit in RUN, so the increment cannot wrap.
   assign last_sweep = ((iter_count + ITER_W'(1)) == limit_r);

   // NOTE: non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
         iter_count <= '0;
         bl_r       <= '0;
         br_r       <= '0;
         limit_r    <= '0;
`ifdef JACOBI_CONV_EN
         tol_r      <= '0;
`endif
         // NOTE: the cell array is reset because u_out must read zero after reset.
         for (int i = 0; i < NU; i++) cells[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NU; i++) cells[i] <= u_init[cell_lsb(i, WIDTH) +: WIDTH];
                  bl_r       <= bnd_left;
                  br_r       <= bnd_right;
                  limit_r    <= max_iters;
`ifdef JACOBI_CONV_EN
                  tol_r      <= tol;
`endif
                  iter_count <= '0;
                  converged  <= 1'b0;
                  if (max_iters == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               for (int i = 0; i < NU; i++) cells[i] <= nxt[i];
               iter_count <= iter_count + ITER_W'(1);
               if (conv_hit) converged <= 1'b1;
               if (last_sweep || conv_hit) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
